// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one line-wide memory port between the I-cache and D-cache.
// Round-robin tie-break; responses and data pass through combinationally to the winner.
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] icache_address,
    input  logic              icache_read,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic [ADDR_W-1:0] pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
    state_t state, next_state;
    logic last_grant;
    logic i_req, d_req;
    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;
    // last_grant = 1 out of reset so the I-cache wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                last_grant <= (next_state == GRANT_D);
        end
    end
    always_comb begin
        next_state   = state;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        icache_resp  = 1'b0;
        icache_rdata = '0;
        dcache_resp  = 1'b0;
        dcache_rdata = '0;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    next_state = last_grant ? GRANT_I : GRANT_D;
                else if (i_req)
                    next_state = GRANT_I;
                else if (d_req)
                    next_state = GRANT_D;
            end
            GRANT_I: begin
                pmem_address = icache_address;
                pmem_read    = icache_read;
                icache_resp  = pmem_resp;
                icache_rdata = pmem_rdata;
                next_state   = pmem_resp ? IDLE : GRANT_I;
            end
            GRANT_D: begin
                // write wins so an illegal read+write never raises both strobes
                pmem_address = dcache_address;
                pmem_write   = dcache_write;
                pmem_read    = dcache_read & ~dcache_write;
                pmem_wdata   = dcache_wdata;
                dcache_resp  = pmem_resp;
                dcache_rdata = pmem_rdata;
                next_state   = pmem_resp ? IDLE : GRANT_D;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks of grant order, pass-through, reset and illegal cases.
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  icache_address, dcache_address, pmem_address;
    logic         icache_read, icache_resp;
    logic [127:0] icache_rdata, dcache_rdata, dcache_wdata, pmem_wdata, pmem_rdata;
    logic         dcache_read, dcache_write, dcache_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    int checks = 0, errors = 0;
    localparam logic [127:0] DATA_A = 128'hDEAD0000_11112222_33334444_0000BEEF;
    localparam logic [127:0] DATA_B = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .icache_address(icache_address), .icache_read(icache_read),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_address(dcache_address), .dcache_read(dcache_read),
        .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        icache_address = '0; icache_read = 1'b0;
        dcache_address = '0; dcache_read = 1'b0; dcache_write = 1'b0; dcache_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        #2;
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_icache_resp", icache_resp, 0);
        chk("rst_dcache_resp", dcache_resp, 0);
        step; step;
        rst_n = 1'b1;

        // lone I-cache read, memory answers four cycles into the grant
        step;
        icache_read = 1'b1; icache_address = 16'h1230;
        #1 chk("i_idle_read", pmem_read, 0);
        step;
        #1 chk("i_pmem_read", pmem_read, 1);
        chk("i_pmem_addr", pmem_address, 16'h1230);
        chk("i_pmem_write", pmem_write, 0);
        step; step;
        #1 chk("i_wait_resp", icache_resp, 0);
        step;
        pmem_resp = 1'b1; pmem_rdata = DATA_A;
        #1 chk("i_resp", icache_resp, 1);
        chk("i_rdata", icache_rdata, DATA_A);
        chk("i_d_resp", dcache_resp, 0);
        chk("i_d_rdata", dcache_rdata, 0);
        step;
        pmem_resp = 1'b0; icache_read = 1'b0;
        #1 chk("i_done_read", pmem_read, 0);
        chk("i_done_resp", icache_resp, 0);

        // lone D-cache writeback
        step;
        dcache_write = 1'b1; dcache_address = 16'h4560; dcache_wdata = PAT_A5;
        #1 chk("d_idle_write", pmem_write, 0);
        step;
        #1 chk("d_pmem_write", pmem_write, 1);
        chk("d_pmem_read", pmem_read, 0);
        chk("d_pmem_addr", pmem_address, 16'h4560);
        chk("d_pmem_wdata", pmem_wdata, PAT_A5);
        step;
        pmem_resp = 1'b1; pmem_rdata = DATA_B;
        #1 chk("d_resp", dcache_resp, 1);
        chk("d_rdata", dcache_rdata, DATA_B);
        chk("d_i_resp", icache_resp, 0);
        step;
        pmem_resp = 1'b0; dcache_write = 1'b0;
        #1 chk("d_done_write", pmem_write, 0);

        // reset in the middle of a D writeback drops everything at once
        step;
        dcache_write = 1'b1; dcache_address = 16'h7770; dcache_wdata = PAT_A5;
        step;
        #1 chk("r_pre_write", pmem_write, 1);
        pmem_resp = 1'b1;
        rst_n = 1'b0;
        #1 chk("r_write", pmem_write, 0);
        chk("r_addr", pmem_address, 0);
        chk("r_wdata", pmem_wdata, 0);
        chk("r_d_resp", dcache_resp, 0);
        chk("r_d_rdata", dcache_rdata, 0);
        step;
        pmem_resp = 1'b0; dcache_write = 1'b0;
        rst_n = 1'b1;
        #1 chk("r_idle_write", pmem_write, 0);

        // both held high: I wins first tie, then strict alternation with an IDLE bubble
        step;
        icache_read = 1'b1; icache_address = 16'h1000;
        dcache_read = 1'b1; dcache_address = 16'h2000;
        for (int k = 0; k < 6; k++) begin
            step;
            #1 chk("rr_addr", pmem_address, (k % 2 == 0) ? 16'h1000 : 16'h2000);
            chk("rr_read", pmem_read, 1);
            pmem_resp = 1'b1; pmem_rdata = DATA_A ^ 128'(k);
            #1 chk("rr_i_resp", icache_resp, (k % 2 == 0) ? 1 : 0);
            chk("rr_d_resp", dcache_resp, (k % 2 == 0) ? 0 : 1);
            step;
            pmem_resp = 1'b0;
            #1 chk("rr_bubble", pmem_read, 0);
        end
        icache_read = 1'b0; dcache_read = 1'b0;

        // illegal read+write together: only the write strobe goes out
        step;
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 16'h3000;
        step;
        #1 chk("x_write", pmem_write, 1);
        chk("x_read", pmem_read, 0);
        pmem_resp = 1'b1;
        #1 chk("x_resp", dcache_resp, 1);
        step;
        pmem_resp = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;

        // stray memory response while idle is not forwarded
        step;
        pmem_resp = 1'b1; pmem_rdata = DATA_B;
        #1 chk("s_i_resp", icache_resp, 0);
        chk("s_d_resp", dcache_resp, 0);
        chk("s_i_rdata", icache_rdata, 0);
        step;
        pmem_resp = 1'b0;
        #1 chk("s_read", pmem_read, 0);
        chk("s_write", pmem_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-requester arbiter that shares the single 128-bit physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. It accepts whole-line read requests from the I-cache and line read/write requests from the D-cache, grants one at a time, and forwards memory data and response back to the winner. Ties are broken round-robin so neither cache can starve the other. It sits between the two L1 caches and the memory/L2 port.

## Interface
Parameters:
- ADDR_W, 16, byte address width (lc3b_word)
- LINE_W, 128, line width (lc3b_mem_data)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- icache_address  in  16  I-cache line address
- icache_read  in  1  I-cache read request; held high until icache_resp
- icache_rdata  out  128  line data to I-cache
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_address  in  16  D-cache line address
- dcache_read  in  1  D-cache read request; held until dcache_resp
- dcache_write  in  1  D-cache writeback request; held until dcache_resp
- dcache_wdata  in  128  writeback line
- dcache_rdata  out  128  line data to D-cache
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- pmem_address  out  16  memory address
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_wdata  out  128  memory write data
- pmem_rdata  in  128  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, GRANT_I, GRANT_D. Register last_grant (0 = I, 1 = D).
- IDLE: all pmem strobes 0, pmem_address/pmem_wdata 0, both resp 0.
  - Only I pending (icache_read) -> GRANT_I. Only D pending (dcache_read|dcache_write) -> GRANT_D.
  - Both pending -> grant the requester that is not last_grant.
  - None pending -> stay IDLE.
- On entry to GRANT_x, last_grant updates to x.
- GRANT_I: pmem_address = icache_address, pmem_read = icache_read, pmem_write = 0. icache_resp = pmem_resp, icache_rdata = pmem_rdata; dcache_resp = 0.
- GRANT_D: pmem_address = dcache_address, pmem_write = dcache_write, pmem_read = dcache_read & ~dcache_write (write wins if both asserted; illegal requester behaviour, must not produce simultaneous strobes). pmem_wdata = dcache_wdata. dcache_resp = pmem_resp, dcache_rdata = pmem_rdata; icache_resp = 0.
- GRANT_x -> IDLE on the cycle pmem_resp = 1; otherwise hold.
- rdata outputs of the non-granted requester are 0. Requester deasserting mid-grant without resp is illegal; arbiter stays in grant until pmem_resp.
- pmem_resp in IDLE is ignored (no resp forwarded).

## Timing
- Reset (rst_n low, asynchronous, any state including mid-transaction): state = IDLE, last_grant = 1 (I wins first tie); all outputs 0 immediately, pmem strobes drop without waiting for pmem_resp.
- Request sampled high at edge N -> state GRANT at N, pmem strobe high in cycle following edge N (1-cycle request-to-memory latency).
- pmem_resp in cycle k -> requester resp in same cycle k (combinational pass-through, zero added latency); state IDLE after edge k+1.
- Requester drops request at edge after its resp; IDLE cycle sees it low.
- Other requester pending across the resp cycle: one IDLE bubble cycle, then granted -> minimum 1 cycle between back-to-back transactions on pmem.
- Outputs to pmem are combinational from state and granted inputs; no glitching strobe when state stable and inputs stable.

## Test plan
- Reset: assert rst_n = 0 mid GRANT_D with pmem_write high -> pmem_write, dcache_resp, all outputs 0 asynchronously; state IDLE after release.
- Lone I-read: icache_read = 1, address 0x1230; memory responds after 4 cycles with 0xDEAD..BEEF -> pmem_read high 1 cycle after request, icache_resp pulse with that data, dcache_resp stays 0.
- Lone D-write: dcache_write = 1, address 0x4560, wdata 0xA5 pattern -> pmem_write = 1, pmem_read = 0, pmem_wdata = pattern; dcache_resp on pmem_resp.
- Simultaneous requests after reset: both asserted same cycle -> I granted first; D granted after one IDLE bubble; next simultaneous tie -> I granted (last was D), alternating thereafter.
- Starvation: D re-requests immediately after every resp while I held high -> grants alternate I, D, I, D; I never waits more than one D transaction.
- Illegal dcache_read & dcache_write together -> only pmem_write asserted; spurious pmem_resp in IDLE produces no resp pulse.
